dmem_arbiter: RTL and testbench

- Shares the single-port 256x8 data RAM between two requesters: the pipeline's stage-three memory port (CPU) and a burst DMA engine built into this block.
- Sits between stage three and D_RAM, and drives the RAM address, enable, write-enable and write data.
- The CPU has priority. A starvation counter guarantees DMA progress, and cpu_odv gives the controller the same stall semantics as d_odv.

---
 rtl/dmem_arbiter_if.sv | 59 +++++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bus bundle between stage three, the burst DMA controls and
//                the single-port 256x8 data RAM, as seen by dmem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
   parameter int LEN_W = 4
);
   // CPU (stage-three memory port)
   logic             cpu_req;
   logic             cpu_we;
   logic [7:0]       cpu_addr;
   logic [7:0]       cpu_wdata;
   logic             cpu_odv;
   logic [7:0]       cpu_rdata;
   logic             cpu_rvalid;

   // DMA burst engine controls
   logic             dma_start;
   logic             dma_we;
   logic [7:0]       dma_base;
   logic [LEN_W-1:0] dma_len;
   logic [7:0]       dma_wdata;
   logic             dma_ack;
   logic [7:0]       dma_rdata;
   logic             dma_rvalid;
   logic             dma_busy;
   logic             dma_done;

   // RAM port
   logic [7:0]       ram_addr;
   logic             ram_en;
   logic             ram_we;
   logic [7:0]       ram_wdata;
   logic [7:0]       ram_rdata;

   // Arbiter side: owns the RAM port and all grant/response signals
   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_odv, cpu_rdata, cpu_rvalid,
      input  dma_start, dma_we, dma_base, dma_len, dma_wdata,
      output dma_ack, dma_rdata, dma_rvalid, dma_busy, dma_done,
      output ram_addr, ram_en, ram_we, ram_wdata,
      input  ram_rdata
   );

   // Environment side: requesters and the RAM itself
   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_odv, cpu_rdata, cpu_rvalid,
      output dma_start, dma_we, dma_base, dma_len, dma_wdata,
      input  dma_ack, dma_rdata, dma_rvalid, dma_busy, dma_done,
      input  ram_addr, ram_en, ram_we, ram_wdata,
      output ram_rdata
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-port data RAM between the CPU memory stage
//                and a built-in burst DMA engine. CPU has priority; a
//                starvation counter bounds how long a pending DMA beat waits.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int LEN_W      = 4
) (
   input  wire logic       g_clk,
   input  wire logic       g_clr,
   dmem_arbiter_if.master  bus
);

   localparam logic [0:0] c_IDLE  = 1'b0;
   localparam logic [0:0] c_BURST = 1'b1;
   localparam int         c_CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [0:0]         state_q,      state_d;
   logic [7:0]         addr_ptr_q,   addr_ptr_d;
   logic [LEN_W-1:0]   beats_left_q, beats_left_d;
   logic               dir_q,        dir_d;
   logic [c_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic               dma_busy_q,   dma_busy_d;
   logic               dma_done_q,   dma_done_d;
   logic               cpu_rvalid_q, cpu_rvalid_d;
   logic               dma_rvalid_q, dma_rvalid_d;

   logic               w_cpu_may_preempt;
   logic               w_cpu_grant;
   logic               w_dma_grant;

   // With STARVE_MAX of zero the CPU never wins while a burst is active
   generate
      if (STARVE_MAX == 0) begin : g_strict_dma
         assign w_cpu_may_preempt = 1'b0;
      end else begin : g_starve_limit
         assign w_cpu_may_preempt = (starve_cnt_q < c_CNT_W'(STARVE_MAX));
      end
   endgenerate

   // Grants depend only on registered state and requests, never on ram_rdata
   assign w_cpu_grant = !g_clr && bus.cpu_req &&
                        ((state_q == c_IDLE) || w_cpu_may_preempt);
   assign w_dma_grant = !g_clr && (state_q == c_BURST) && !w_cpu_grant;

   // Steer the RAM port to the single owner of this cycle
   always_comb begin
      bus.cpu_odv   = w_cpu_grant;
      bus.dma_ack   = w_dma_grant;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = 8'h00;
      bus.ram_wdata = 8'h00;
      if (w_cpu_grant) begin
         bus.ram_en    = 1'b1;
         bus.ram_we    = bus.cpu_we;
         bus.ram_addr  = bus.cpu_addr;
         bus.ram_wdata = bus.cpu_wdata;
      end else if (w_dma_grant) begin
         bus.ram_en    = 1'b1;
         bus.ram_we    = dir_q;
         bus.ram_addr  = addr_ptr_q;
         bus.ram_wdata = bus.dma_wdata;
      end
   end

   assign bus.cpu_rdata  = bus.ram_rdata;
   assign bus.dma_rdata  = bus.ram_rdata;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.dma_rvalid = dma_rvalid_q;
   assign bus.dma_busy   = dma_busy_q;
   assign bus.dma_done   = dma_done_q;

   // Next-state: burst sequencing, starvation counting and read-return flags
   always_comb begin
      state_d      = state_q;
      addr_ptr_d   = addr_ptr_q;
      beats_left_d = beats_left_q;
      dir_d        = dir_q;
      starve_cnt_d = starve_cnt_q;
      dma_busy_d   = dma_busy_q;
      cpu_rvalid_d = w_cpu_grant && !bus.cpu_we;
      dma_rvalid_d = w_dma_grant && !dir_q;
      dma_done_d   = w_dma_grant && (beats_left_q == '0);

      case (state_q)
         c_IDLE: begin
            starve_cnt_d = '0;
            if (bus.dma_start) begin
               addr_ptr_d   = bus.dma_base;
               beats_left_d = bus.dma_len;
               dir_d        = bus.dma_we;
               dma_busy_d   = 1'b1;
               state_d      = c_BURST;
            end
         end
         c_BURST: begin
            if (w_cpu_grant) begin
               starve_cnt_d = starve_cnt_q + c_CNT_W'(1);
            end else if (w_dma_grant) begin
               starve_cnt_d = '0;
               addr_ptr_d   = addr_ptr_q + 8'd1;
               if (beats_left_q == '0) begin
                  dma_busy_d = 1'b0;
                  state_d    = c_IDLE;
               end else begin
                  beats_left_d = beats_left_q - LEN_W'(1);
               end
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // State registers with synchronous clear; a clear abandons any burst
   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         state_q      <= c_IDLE;
         addr_ptr_q   <= 8'h00;
         beats_left_q <= '0;
         dir_q        <= 1'b0;
         starve_cnt_q <= '0;
         dma_busy_q   <= 1'b0;
         dma_done_q   <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_ptr_q   <= addr_ptr_d;
         beats_left_q <= beats_left_d;
         dir_q        <= dir_d;
         starve_cnt_q <= starve_cnt_d;
         dma_busy_q   <= dma_busy_d;
         dma_done_q   <= dma_done_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Bench for dmem_arbiter. Two instances share one stimulus
//                stream: index 0 with STARVE_MAX=4, index 1 with STARVE_MAX=0.
//                A transaction-level model predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int LEN_W = 4;
   localparam int NDUT  = 2;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   logic             cpu_req, cpu_we, dma_start, dma_we;
   logic [7:0]       cpu_addr, cpu_wdata, dma_base, dma_wdata;
   logic [LEN_W-1:0] dma_len;

   logic [NDUT-1:0]  o_odv, o_ack, o_en, o_we, o_crv, o_drv, o_busy, o_done;
   logic [7:0]       o_addr [NDUT];
   logic [7:0]       o_wdata[NDUT];
   logic [7:0]       o_crd  [NDUT];
   logic [7:0]       o_drd  [NDUT];

   int n_vec  = 0;
   int n_miss = 0;

   function automatic logic [7:0] init_val(input int a);
      return 8'(a) ^ 8'h5A;
   endfunction

   function automatic int smax(input int k);
      return (k == 0) ? 4 : 0;
   endfunction

   dmem_arbiter_if #(.LEN_W(LEN_W)) bus [NDUT] ();

   genvar k;
   generate
      for (k = 0; k < NDUT; k++) begin : g_dut
         logic [7:0] mem [256];
         logic [7:0] rd_q;

         initial for (int a = 0; a < 256; a++) mem[a] = init_val(a);

         // RAM model: write at the edge, read data registered one cycle later
         always @(posedge clk) begin
            if (bus[k].ram_en && bus[k].ram_we) mem[bus[k].ram_addr] <= bus[k].ram_wdata;
            if (bus[k].ram_en && !bus[k].ram_we) rd_q <= mem[bus[k].ram_addr];
         end

         assign bus[k].cpu_req   = cpu_req;
         assign bus[k].cpu_we    = cpu_we;
         assign bus[k].cpu_addr  = cpu_addr;
         assign bus[k].cpu_wdata = cpu_wdata;
         assign bus[k].dma_start = dma_start;
         assign bus[k].dma_we    = dma_we;
         assign bus[k].dma_base  = dma_base;
         assign bus[k].dma_len   = dma_len;
         assign bus[k].dma_wdata = dma_wdata;
         assign bus[k].ram_rdata = rd_q;

         assign o_odv[k]   = bus[k].cpu_odv;
         assign o_ack[k]   = bus[k].dma_ack;
         assign o_en[k]    = bus[k].ram_en;
         assign o_we[k]    = bus[k].ram_we;
         assign o_crv[k]   = bus[k].cpu_rvalid;
         assign o_drv[k]   = bus[k].dma_rvalid;
         assign o_busy[k]  = bus[k].dma_busy;
         assign o_done[k]  = bus[k].dma_done;
         assign o_addr[k]  = bus[k].ram_addr;
         assign o_wdata[k] = bus[k].ram_wdata;
         assign o_crd[k]   = bus[k].cpu_rdata;
         assign o_drd[k]   = bus[k].dma_rdata;

         dmem_arbiter #(.STARVE_MAX(k == 0 ? 4 : 0), .LEN_W(LEN_W)) u_dut (
            .g_clk (clk),
            .g_clr (clr),
            .bus   (bus[k])
         );
      end
   endgenerate

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // A burst is a precomputed list of addresses; each DMA beat consumes one.
   logic       m_busy [NDUT];
   logic       m_dir  [NDUT];
   logic [7:0] m_list [NDUT][16];
   int         m_head [NDUT];
   int         m_cnt  [NDUT];
   int         m_run  [NDUT];
   logic       m_done [NDUT];
   logic       m_crv  [NDUT];
   logic       m_drv  [NDUT];
   logic [7:0] m_crd  [NDUT];
   logic [7:0] m_drd  [NDUT];
   logic [7:0] m_mem  [NDUT][256];

   task automatic model_clear(input int k);
      m_busy[k] = 1'b0; m_head[k] = 0; m_cnt[k] = 0; m_run[k] = 0;
      m_done[k] = 1'b0; m_crv[k] = 1'b0; m_drv[k] = 1'b0;
   endtask

   task automatic model_cycle(input int k);
      logic       cw, dw, ee, ewe, was_busy;
      logic [7:0] ea, ewd;
      cw = 1'b0; dw = 1'b0; ee = 1'b0; ewe = 1'b0; ea = 8'h00; ewd = 8'h00;
      if (!clr) begin
         cw = cpu_req && (!m_busy[k] || (m_run[k] < smax(k)));
         dw = m_busy[k] && !cw;
      end
      if (cw) begin
         ee = 1'b1; ewe = cpu_we; ea = cpu_addr; ewd = cpu_wdata;
      end else if (dw) begin
         ee = 1'b1; ewe = m_dir[k]; ea = m_list[k][m_head[k]]; ewd = dma_wdata;
      end
      check($sformatf("cpu_odv[%0d]", k),    8'(o_odv[k]),  8'(cw));
      check($sformatf("dma_ack[%0d]", k),    8'(o_ack[k]),  8'(dw));
      check($sformatf("ram_en[%0d]", k),     8'(o_en[k]),   8'(ee));
      check($sformatf("ram_we[%0d]", k),     8'(o_we[k]),   8'(ewe));
      check($sformatf("ram_addr[%0d]", k),   o_addr[k],     ea);
      check($sformatf("ram_wdata[%0d]", k),  o_wdata[k],    ewd);
      check($sformatf("dma_busy[%0d]", k),   8'(o_busy[k]), 8'(m_busy[k]));
      check($sformatf("dma_done[%0d]", k),   8'(o_done[k]), 8'(m_done[k]));
      check($sformatf("cpu_rvalid[%0d]", k), 8'(o_crv[k]),  8'(m_crv[k]));
      check($sformatf("dma_rvalid[%0d]", k), 8'(o_drv[k]),  8'(m_drv[k]));
      if (m_crv[k]) check($sformatf("cpu_rdata[%0d]", k), o_crd[k], m_crd[k]);
      if (m_drv[k]) check($sformatf("dma_rdata[%0d]", k), o_drd[k], m_drd[k]);

      if (clr) begin
         model_clear(k);
      end else begin
         m_crv[k] = cw && !cpu_we;
         m_crd[k] = m_mem[k][cpu_addr];
         m_drv[k] = dw && !m_dir[k];
         m_drd[k] = m_mem[k][ea];
         if (ee && ewe) m_mem[k][ea] = ewd;
         m_done[k] = dw && (m_cnt[k] - m_head[k] == 1);
         was_busy = m_busy[k];
         if (dw) begin
            m_head[k]++;
            m_run[k] = 0;
            if (m_head[k] == m_cnt[k]) m_busy[k] = 1'b0;
         end else if (cw && was_busy) begin
            m_run[k]++;
         end
         if (!was_busy && dma_start) begin
            m_cnt[k]  = int'(dma_len) + 1;
            for (int i = 0; i < m_cnt[k]; i++) m_list[k][i] = dma_base + 8'(i);
            m_head[k] = 0;
            m_run[k]  = 0;
            m_dir[k]  = dma_we;
            m_busy[k] = 1'b1;
         end
      end
   endtask

   // Per-cycle compare of both instances against the model
   initial begin
      for (int j = 0; j < NDUT; j++) begin
         model_clear(j);
         m_dir[j] = 1'b0;
         for (int a = 0; a < 256; a++) m_mem[j][a] = init_val(a);
      end
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int j = 0; j < NDUT; j++) model_cycle(j);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic settle();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] t2_addrs;
      logic [12:0] t3_pat;
      logic [4:0]  t4_pat;
      int          n_done;

      clr = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      dma_start = 1'b0; dma_we = 1'b0; dma_base = 8'h00; dma_len = '0; dma_wdata = 8'h00;

      // Reset state
      nxt();
      settle();
      check("reset dma_busy", 8'(o_busy[0]), 8'h00);
      check("reset cpu_odv",  8'(o_odv[0]),  8'h00);
      check("reset ram_en",   8'(o_en[0]),   8'h00);
      nxt();
      clr = 1'b0;

      // 1: CPU write 0x3C to 0x10, then read it back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h3C;
      settle();
      check("t1 write odv", 8'(o_odv[0]), 8'h01);
      nxt();
      cpu_we = 1'b0;
      settle();
      check("t1 read odv", 8'(o_odv[0]), 8'h01);
      nxt();
      cpu_req = 1'b0;
      settle();
      check("t1 cpu_rvalid", 8'(o_crv[0]), 8'h01);
      check("t1 cpu_rdata",  o_crd[0],     8'h3C);

      // 2: DMA write burst FE..01 with wrap, then CPU read of 0x01
      nxt();
      dma_start = 1'b1; dma_we = 1'b1; dma_base = 8'hFE; dma_len = 4'd3;
      settle();
      check("t2 busy before", 8'(o_busy[0]), 8'h00);
      nxt();
      dma_start = 1'b0;
      t2_addrs = 32'hFEFF_0001;
      for (int i = 0; i < 4; i++) begin
         dma_wdata = 8'hA0 + 8'(i);
         settle();
         check("t2 dma_ack",  8'(o_ack[0]),  8'h01);
         check("t2 ram_addr", o_addr[0],     t2_addrs[31-8*i -: 8]);
         check("t2 dma_busy", 8'(o_busy[0]), 8'h01);
         nxt();
      end
      settle();
      check("t2 dma_done",   8'(o_done[0]), 8'h01);
      check("t2 busy after", 8'(o_busy[0]), 8'h00);
      nxt();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
      settle();
      nxt();
      cpu_req = 1'b0;
      settle();
      check("t2 readback", o_crd[0], 8'hA3);

      // 3: starvation pattern with CPU held, DMA read burst of two beats
      nxt();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
      dma_start = 1'b1; dma_we = 1'b0; dma_base = 8'h40; dma_len = 4'd1;
      t3_pat = 13'b11111_0_1111_0_11;
      for (int i = 0; i < 13; i++) begin
         if (i == 1) dma_start = 1'b0;
         settle();
         check("t3 odv pattern", 8'(o_odv[0]), 8'(t3_pat[12-i]));
         if (i == 5)  check("t3 beat0 addr", o_addr[0], 8'h40);
         if (i == 10) check("t3 beat1 addr", o_addr[0], 8'h41);
         if (i == 11) begin
            check("t3 dma_done",   8'(o_done[0]), 8'h01);
            check("t3 dma_rvalid", 8'(o_drv[0]),  8'h01);
         end
         nxt();
      end
      cpu_req = 1'b0;
      nxt();

      // 4: strict DMA priority on instance 1 (STARVE_MAX=0)
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h31;
      dma_start = 1'b1; dma_we = 1'b1; dma_base = 8'h90; dma_len = 4'd2; dma_wdata = 8'h77;
      t4_pat = 5'b1_000_1;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) dma_start = 1'b0;
         settle();
         check("t4 odv strict", 8'(o_odv[1]), 8'(t4_pat[4-i]));
         if (i >= 1 && i <= 3) check("t4 addr", o_addr[1], 8'h90 + 8'(i - 1));
         nxt();
      end
      cpu_req = 1'b0;
      repeat (5) nxt();

      // 5: start re-asserted mid-burst is ignored
      dma_start = 1'b1; dma_we = 1'b1; dma_base = 8'h50; dma_len = 4'd5; dma_wdata = 8'h11;
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) dma_start = 1'b0;
         if (i == 2) begin dma_start = 1'b1; dma_base = 8'h80; end
         if (i == 4) dma_start = 1'b0;
         settle();
         if (i >= 1 && i <= 6) check("t5 addr", o_addr[0], 8'h50 + 8'(i - 1));
         if (i == 7) check("t5 busy low", 8'(o_busy[0]), 8'h00);
         if (o_done[0]) n_done++;
         nxt();
      end
      check("t5 done count", 8'(n_done), 8'h01);

      // 6: clear mid-burst with a read in flight, then a fresh burst from 0x20
      dma_start = 1'b1; dma_we = 1'b0; dma_base = 8'h60; dma_len = 4'd7;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) dma_start = 1'b0;
         if (i == 3) clr = 1'b1;
         if (i == 4) begin
            clr = 1'b0;
            dma_start = 1'b1; dma_base = 8'h20; dma_len = 4'd1;
         end
         if (i == 5) dma_start = 1'b0;
         settle();
         if (i == 3) begin
            check("t6 clr ack", 8'(o_ack[0]), 8'h00);
            check("t6 clr en",  8'(o_en[0]),  8'h00);
         end
         if (i == 4) begin
            check("t6 busy cleared",   8'(o_busy[0]), 8'h00);
            check("t6 rvalid dropped", 8'(o_drv[0]),  8'h00);
            check("t6 no done",        8'(o_done[0]), 8'h00);
         end
         if (i == 5) check("t6 new addr0", o_addr[0], 8'h20);
         if (i == 6) check("t6 new addr1", o_addr[0], 8'h21);
         if (i == 7) check("t6 new done",  8'(o_done[0]), 8'h01);
         nxt();
      end

      repeat (3) nxt();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
